// File: rtl/cc_win_detector_pkg.sv
// Shared state encoding and width helpers for the home-slot win detector.
package cc_win_detector_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_PLAY = 2'd0;
  localparam state_t ST_WIN  = 2'd1;
  localparam state_t ST_LOSE = 2'd2;

  // Width of a counter that must hold the value n itself (never less than 1 bit).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of an index selecting one of n items.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_CNT_W   = cnt_width(3);
  localparam int DEF_TMR_W   = cnt_width(1000);
  localparam int DEF_IDX_W   = idx_width(4);

endpackage

// File: rtl/cc_win_slotmatch.sv
// Combinational priority match: lowest-index unfilled slot whose target equals data.
module cc_win_slotmatch
  import cc_win_detector_pkg::*;
#(
  parameter int DW    = 8,
  parameter int NS    = 4,
  parameter int IDX_W = idx_width(NS)
) (
  input  logic [DW-1:0]    data,
  input  logic [NS*DW-1:0] targets,
  input  logic [NS-1:0]    filled,
  output logic             cand_valid,
  output logic [IDX_W-1:0] cand_idx
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (!filled[i] && (targets[i*DW +: DW] == data)) begin
        cand_valid = 1'b1;
        cand_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cc_win_detector.sv
// Fill every home slot by holding position on its target before the play timer expires.
module cc_win_detector
  import cc_win_detector_pkg::*;
#(
  parameter int WINDETECTOR_DATAWIDTH  = 8,
  parameter int WINDETECTOR_NUMSLOTS   = 4,
  parameter int WINDETECTOR_HOLDCYCLES = 3,
  parameter int WINDETECTOR_TIMEOUT    = 1000
) (
  input  logic                                              CC_WINDETECTOR_CLOCK_50,
  input  logic                                              CC_WINDETECTOR_RESET_InLow,
  input  logic                                              CC_WINDETECTOR_clear_InHigh,
  input  logic                                              CC_WINDETECTOR_valid_InHigh,
  input  logic [WINDETECTOR_DATAWIDTH-1:0]                  CC_WINDETECTOR_data_InBUS,
  input  logic [WINDETECTOR_NUMSLOTS*WINDETECTOR_DATAWIDTH-1:0] CC_WINDETECTOR_target_InBUS,
  output logic [WINDETECTOR_NUMSLOTS-1:0]                   CC_WINDETECTOR_filled_OutBUS,
  output logic                                              CC_WINDETECTOR_slothit_OutHigh,
  output logic                                              CC_WINDETECTOR_win_OutLow,
  output logic                                              CC_WINDETECTOR_lose_OutLow,
  output logic [1:0]                                        dbg_state
);

  localparam int DW    = WINDETECTOR_DATAWIDTH;
  localparam int NS    = WINDETECTOR_NUMSLOTS;
  localparam int HOLD  = WINDETECTOR_HOLDCYCLES;
  localparam int TMO   = WINDETECTOR_TIMEOUT;
  localparam int IDX_W = idx_width(NS);
  localparam int CNT_W = cnt_width(HOLD);
  localparam int TMR_W = cnt_width(TMO);

  state_t             state, state_d;
  logic [NS-1:0]      filled, filled_d;
  logic               slothit, slothit_d;
  logic               win_n, lose_n;
  logic [CNT_W-1:0]   hold_cnt, hold_d;
  logic [IDX_W-1:0]   latched_idx, latched_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic               cand_valid;
  logic [IDX_W-1:0]   cand_idx;
  int                 run;

  cc_win_slotmatch #(.DW(DW), .NS(NS), .IDX_W(IDX_W)) u_match (
    .data       (CC_WINDETECTOR_data_InBUS),
    .targets    (CC_WINDETECTOR_target_InBUS),
    .filled     (filled),
    .cand_valid (cand_valid),
    .cand_idx   (cand_idx)
  );

  // valid qualifies data for one cycle; with valid low the hold tracking is frozen.
  always_comb begin
    state_d   = state;
    filled_d  = filled;
    slothit_d = 1'b0;
    hold_d    = hold_cnt;
    latched_d = latched_idx;
    timer_d   = timer;
    run       = 0;
    if (CC_WINDETECTOR_clear_InHigh) begin
      state_d   = ST_PLAY;
      filled_d  = '0;
      hold_d    = '0;
      latched_d = '0;
      timer_d   = '0;
    end else if (state == ST_PLAY) begin
      if (TMO != 0) timer_d = timer + TMR_W'(1);
      if (CC_WINDETECTOR_valid_InHigh) begin
        if (!cand_valid) begin
          hold_d = '0;
        end else begin
          // A different candidate restarts the run at one rather than zero.
          run       = (cand_idx == latched_idx) ? int'(hold_cnt) + 1 : 1;
          latched_d = cand_idx;
          if (run >= HOLD) begin
            filled_d[cand_idx] = 1'b1;
            slothit_d          = 1'b1;
            hold_d             = '0;
          end else begin
            hold_d = CNT_W'(run);
          end
        end
      end
      if (&filled_d) state_d = ST_WIN;
      else if ((TMO != 0) && (int'(timer) + 1 >= TMO)) state_d = ST_LOSE;
    end
  end

  always_ff @(posedge CC_WINDETECTOR_CLOCK_50 or negedge CC_WINDETECTOR_RESET_InLow) begin
    if (!CC_WINDETECTOR_RESET_InLow) begin
      state       <= ST_PLAY;
      filled      <= '0;
      slothit     <= 1'b0;
      win_n       <= 1'b1;
      lose_n      <= 1'b1;
      hold_cnt    <= '0;
      latched_idx <= '0;
      timer       <= '0;
    end else begin
      state       <= state_d;
      filled      <= filled_d;
      slothit     <= slothit_d;
      win_n       <= (state_d != ST_WIN);
      lose_n      <= (state_d != ST_LOSE);
      hold_cnt    <= hold_d;
      latched_idx <= latched_d;
      timer       <= timer_d;
    end
  end

  assign CC_WINDETECTOR_filled_OutBUS   = filled;
  assign CC_WINDETECTOR_slothit_OutHigh = slothit;
  assign CC_WINDETECTOR_win_OutLow      = win_n;
  assign CC_WINDETECTOR_lose_OutLow     = lose_n;
  assign dbg_state                      = state;

endmodule

// File: tb/tb_cc_win_detector.sv
// Bench for cc_win_detector: directed scenarios plus random play against a slot/streak model.
module tb_cc_win_detector;

  localparam int DW   = 8;
  localparam int NS   = 4;
  localparam int HOLD = 3;
  localparam int TMO  = 100;
  localparam int W    = NS + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          valid;
  logic [DW-1:0] data;
  logic [NS*DW-1:0] tgt;
  logic [NS-1:0] filled;
  logic          slothit;
  logic          win_n;
  logic          lose_n;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  // Model: outcome 0 = still playing, 1 = won, 2 = lost.
  int       m_outcome;
  bit [NS-1:0] m_filled;
  int       m_track;
  int       m_len;
  int       m_elapsed;

  cc_win_detector #(
    .WINDETECTOR_DATAWIDTH (DW),
    .WINDETECTOR_NUMSLOTS  (NS),
    .WINDETECTOR_HOLDCYCLES(HOLD),
    .WINDETECTOR_TIMEOUT   (TMO)
  ) dut (
    .CC_WINDETECTOR_CLOCK_50       (clk),
    .CC_WINDETECTOR_RESET_InLow    (rst_n),
    .CC_WINDETECTOR_clear_InHigh   (clear),
    .CC_WINDETECTOR_valid_InHigh   (valid),
    .CC_WINDETECTOR_data_InBUS     (data),
    .CC_WINDETECTOR_target_InBUS   (tgt),
    .CC_WINDETECTOR_filled_OutBUS  (filled),
    .CC_WINDETECTOR_slothit_OutHigh(slothit),
    .CC_WINDETECTOR_win_OutLow     (win_n),
    .CC_WINDETECTOR_lose_OutLow    (lose_n),
    .dbg_state                     (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_outcome = 0;
    m_filled  = '0;
    m_track   = -1;
    m_len     = 0;
    m_elapsed = 0;
  endtask

  function automatic logic [DW-1:0] target_of(input int i);
    logic [NS*DW-1:0] t;
    t = tgt >> (DW * i);
    return t[DW-1:0];
  endfunction

  task automatic model_step(input logic clr, input logic vld, input logic [DW-1:0] d);
    bit hit;
    int c;
    hit = 1'b0;
    if (clr) begin
      model_reset();
    end else if (m_outcome == 0) begin
      m_elapsed++;
      if (vld) begin
        c = -1;
        for (int i = NS - 1; i >= 0; i--)
          if (!m_filled[i] && target_of(i) == d) c = i;
        if (c < 0) m_len = 0;
        else if (c == m_track) m_len++;
        else begin
          m_track = c;
          m_len   = 1;
        end
        if (c >= 0 && m_len == HOLD) begin
          m_filled[c] = 1'b1;
          hit         = 1'b1;
          m_len       = 0;
        end
      end
      if (&m_filled) m_outcome = 1;
      else if (m_elapsed >= TMO) m_outcome = 2;
    end
    exp_q.push_back({m_filled, hit, (m_outcome != 1), (m_outcome != 2)});
  endtask

  task automatic compare_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("filled", 32'(filled), 32'(e[W-1:3]));
      check("slothit", 32'(slothit), 32'(e[2]));
      check("win_n", 32'(win_n), 32'(e[1]));
      check("lose_n", 32'(lose_n), 32'(e[0]));
    end
  endtask

  // Driver: inputs change after a falling edge, outputs are checked on the next falling edge.
  task automatic drive_cycle(input logic clr, input logic vld, input logic [DW-1:0] d);
    clear = clr;
    valid = vld;
    data  = d;
    @(posedge clk);
    model_step(clr, vld, d);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic hold_on(input logic [DW-1:0] d, input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_filled"}, 32'(filled), 32'd0);
    check({tag, "_slothit"}, 32'(slothit), 32'd0);
    check({tag, "_win_n"}, 32'(win_n), 32'd1);
    check({tag, "_lose_n"}, 32'(lose_n), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    valid = 1'b0;
    data  = '0;
    tgt   = 32'h4030_2010;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Hold on slot 1 for three cycles.
    hold_on(8'h20, 3);
    check("hold3_filled", 32'(filled), 32'b0010);
    check("hold3_pulse", 32'(slothit), 32'd1);
    idle(1);
    check("pulse_one_cycle", 32'(slothit), 32'd0);

    // Valid low freezes the run.
    drive_cycle(1'b1, 1'b0, 8'h00);
    hold_on(8'h30, 2);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 8'h30);
    check("freeze_nofill", 32'(filled), 32'b0000);
    hold_on(8'h30, 1);
    check("freeze_fill", 32'(filled), 32'b0100);

    // A miss breaks the run.
    drive_cycle(1'b1, 1'b0, 8'h00);
    hold_on(8'h10, 2);
    hold_on(8'h11, 1);
    hold_on(8'h10, 2);
    check("break_nofill", 32'(filled), 32'b0000);
    hold_on(8'h10, 1);
    check("break_fill", 32'(filled), 32'b0001);

    // Fill all four in order, then ignore data until clear.
    drive_cycle(1'b1, 1'b0, 8'h00);
    for (int s = 0; s < NS; s++) hold_on(target_of(s), HOLD);
    check("win_low", 32'(win_n), 32'd0);
    hold_on(8'h10, 5);
    check("win_hold_filled", 32'(filled), 32'b1111);
    drive_cycle(1'b1, 1'b0, 8'h00);
    check("clear_win", 32'(win_n), 32'd1);
    check("clear_filled", 32'(filled), 32'b0000);

    // Clear beats a simultaneous fill.
    hold_on(8'h40, 2);
    drive_cycle(1'b1, 1'b1, 8'h40);
    check("clear_beats_fill", 32'(filled), 32'b0000);

    // Timeout after exactly TMO cycles with no progress.
    idle(TMO - 1);
    check("lose_not_yet", 32'(lose_n), 32'd1);
    idle(1);
    check("lose_low", 32'(lose_n), 32'd0);
    hold_on(8'h10, 4);
    check("lose_ignores", 32'(filled), 32'b0000);

    // Final fill landing on the timeout edge wins.
    drive_cycle(1'b1, 1'b0, 8'h00);
    for (int s = 0; s < NS - 1; s++) hold_on(target_of(s), HOLD);
    idle(TMO - HOLD * NS);
    hold_on(8'h40, HOLD);
    check("tie_win", 32'(win_n), 32'd0);
    check("tie_lose", 32'(lose_n), 32'd1);

    // Asynchronous reset in the middle of a hold.
    drive_cycle(1'b1, 1'b0, 8'h00);
    hold_on(8'h10, HOLD);
    hold_on(8'h20, 2);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    hold_on(8'h20, 2);
    check("post_reset_nofill", 32'(filled), 32'b0000);
    hold_on(8'h20, 1);
    check("post_reset_fill", 32'(filled), 32'b0010);

    // Random play, including target changes and occasional clears.
    drive_cycle(1'b1, 1'b0, 8'h00);
    for (int n = 0; n < 1500; n++) begin
      logic [DW-1:0] d;
      if ($urandom_range(99) < 2)
        tgt[$urandom_range(NS - 1) * DW +: DW] = 8'($urandom_range(8'h08, 8'h48));
      d = ($urandom_range(99) < 80) ? target_of($urandom_range(NS - 1)) : 8'($urandom);
      drive_cycle(($urandom_range(99) < 2), ($urandom_range(99) < 75), d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
